icache_fetch: RTL and testbench

//  Direct-mapped instruction cache between the fetch stage and memctrl's icache port.

---
 rtl/icache_fetch.sv | 153 +++++++++++++++
 tb/tb_icache_fetch.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache between the fetch stage and memctrl's icache port.
// Hits answer in one cycle; misses fetch a 128-bit line and answer on the fill edge.
module icache_fetch #(
   parameter int INDEX_W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rdy,
   input  logic         flush,
   input  logic         if_req,
   input  logic [31:0]  if_addr,
   output logic         if_ready,
   output logic         if_done,
   output logic [31:0]  if_inst,
   output logic         icache_rd_valid,
   output logic [31:0]  icache_rd_addr,
   input  logic         icache_ena,
   input  logic [127:0] icache_rd_line
);

   localparam int LINES = 1 << INDEX_W;
   localparam int TAG_W = 28 - INDEX_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MISS  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   function automatic logic [31:0] word_sel(input logic [127:0] line, input logic [1:0] w);
      case (w)
         2'd0:    word_sel = line[31:0];
         2'd1:    word_sel = line[63:32];
         2'd2:    word_sel = line[95:64];
         default: word_sel = line[127:96];
      endcase
   endfunction

   state_t             state_q, state_d;
   logic [LINES-1:0]   valid_q;
   logic [TAG_W-1:0]   tag_mem  [LINES];
   logic [127:0]       data_mem [LINES];

   logic               if_done_q, if_done_d;
   logic [31:0]        if_inst_q, if_inst_d;
   logic               rd_valid_q, rd_valid_d;
   logic [31:0]        rd_addr_q, rd_addr_d;

   logic [INDEX_W-1:0] miss_idx_q;
   logic [TAG_W-1:0]   miss_tag_q;
   logic [1:0]         miss_word_q;

   logic [INDEX_W-1:0] req_idx;
   logic [TAG_W-1:0]   req_tag;
   logic [1:0]         req_word;
   logic               hit;
   logic               fill;
   logic               latch_miss;
   logic               unused_addr_bits;

   assign req_idx          = if_addr[3+INDEX_W:4];
   assign req_tag          = if_addr[31:4+INDEX_W];
   assign req_word         = if_addr[3:2];
   assign unused_addr_bits = ^if_addr[1:0];
   assign hit              = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

   always_comb begin
      state_d    = state_q;
      if_done_d  = 1'b0;
      if_inst_d  = if_inst_q;
      rd_valid_d = rd_valid_q;
      rd_addr_d  = rd_addr_q;
      fill       = 1'b0;
      latch_miss = 1'b0;
      case (state_q)
         IDLE: begin
            if (if_req && !flush) begin
               if (hit) begin
                  if_done_d = 1'b1;
                  if_inst_d = word_sel(data_mem[req_idx], req_word);
               end else begin
                  rd_valid_d = 1'b1;
                  rd_addr_d  = {if_addr[31:4], 4'b0000};
                  latch_miss = 1'b1;
                  state_d    = MISS;
               end
            end
         end
         MISS: begin
            // A line already requested always completes; flush only suppresses the reply.
            if (icache_ena) begin
               fill       = 1'b1;
               rd_valid_d = 1'b0;
               state_d    = IDLE;
               if (!flush) begin
                  if_done_d = 1'b1;
                  if_inst_d = word_sel(icache_rd_line, miss_word_q);
               end
            end else if (flush) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (icache_ena) begin
               fill       = 1'b1;
               rd_valid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         valid_q    <= '0;
         if_done_q  <= 1'b0;
         if_inst_q  <= 32'd0;
         rd_valid_q <= 1'b0;
         rd_addr_q  <= 32'd0;
      end else if (rdy) begin
         state_q    <= state_d;
         if_done_q  <= if_done_d;
         if_inst_q  <= if_inst_d;
         rd_valid_q <= rd_valid_d;
         rd_addr_q  <= rd_addr_d;
         if (fill) valid_q[miss_idx_q] <= 1'b1;
      end
   end

   // Arrays and miss bookkeeping carry no reset; valid_q alone qualifies them.
   always_ff @(posedge clk) begin
      if (rdy) begin
         if (fill) begin
            tag_mem[miss_idx_q]  <= miss_tag_q;
            data_mem[miss_idx_q] <= icache_rd_line;
         end
         if (latch_miss) begin
            miss_idx_q  <= req_idx;
            miss_tag_q  <= req_tag;
            miss_word_q <= req_word;
         end
      end
   end

   assign if_ready        = (state_q == IDLE);
   assign if_done         = if_done_q;
   assign if_inst         = if_inst_q;
   assign icache_rd_valid = rd_valid_q;
   assign icache_rd_addr  = rd_addr_q;

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: cold miss, hit streaming, conflict, flush, stall, async reset.
module tb_icache_fetch;

   logic         clk = 1'b0;
   logic         rst;
   logic         rdy;
   logic         flush;
   logic         if_req;
   logic [31:0]  if_addr;
   logic         if_ready;
   logic         if_done;
   logic [31:0]  if_inst;
   logic         icache_rd_valid;
   logic [31:0]  icache_rd_addr;
   logic         icache_ena;
   logic [127:0] icache_rd_line;

   int errors = 0;
   int checks = 0;

   localparam logic [127:0] L1 = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] L2 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
   localparam logic [127:0] L3 = 128'h88888888_77777777_66666666_55555555;
   localparam logic [127:0] L4 = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
   localparam logic [127:0] L5 = 128'h0B0B0B03_0B0B0B02_0B0B0B01_0B0B0B00;
   localparam logic [127:0] LX = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

   icache_fetch #(.INDEX_W(6)) dut (
      .clk             (clk),
      .rst             (rst),
      .rdy             (rdy),
      .flush           (flush),
      .if_req          (if_req),
      .if_addr         (if_addr),
      .if_ready        (if_ready),
      .if_done         (if_done),
      .if_inst         (if_inst),
      .icache_rd_valid (icache_rd_valid),
      .icache_rd_addr  (icache_rd_addr),
      .icache_ena      (icache_ena),
      .icache_rd_line  (icache_rd_line)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst            = 1'b1;
      rdy            = 1'b1;
      flush          = 1'b0;
      if_req         = 1'b0;
      if_addr        = 32'd0;
      icache_ena     = 1'b0;
      icache_rd_line = '0;
      #1 rst = 1'b0;
      tick();
      tick();
      chk("rst_done",     {31'd0, if_done},         32'd0);
      chk("rst_inst",     if_inst,                  32'd0);
      chk("rst_rdvalid",  {31'd0, icache_rd_valid}, 32'd0);
      chk("rst_rdaddr",   icache_rd_addr,           32'd0);
      chk("rst_ready",    {31'd0, if_ready},        32'd1);
      rst = 1'b1;
      tick();

      // Test 1: cold miss
      if_req = 1'b1; if_addr = 32'h0000_1008;
      tick();
      if_req = 1'b0;
      chk("t1_rdvalid",   {31'd0, icache_rd_valid}, 32'd1);
      chk("t1_rdaddr",    icache_rd_addr,           32'h0000_1000);
      chk("t1_ready",     {31'd0, if_ready},        32'd0);
      chk("t1_done0",     {31'd0, if_done},         32'd0);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("t1_wait_done",  {31'd0, if_done},         32'd0);
         chk("t1_wait_valid", {31'd0, icache_rd_valid}, 32'd1);
      end
      icache_ena = 1'b1; icache_rd_line = L1;
      tick();
      icache_ena = 1'b0;
      chk("t1_done",      {31'd0, if_done},         32'd1);
      chk("t1_inst",      if_inst,                  32'h3333_3333);
      chk("t1_rdvalid0",  {31'd0, icache_rd_valid}, 32'd0);
      chk("t1_ready1",    {31'd0, if_ready},        32'd1);

      // Test 2: hit streaming
      if_req = 1'b1; if_addr = 32'h0000_1000;
      tick();
      chk("t2_done_a",    {31'd0, if_done},         32'd1);
      chk("t2_inst_a",    if_inst,                  32'h1111_1111);
      if_addr = 32'h0000_1004;
      tick();
      chk("t2_done_b",    {31'd0, if_done},         32'd1);
      chk("t2_inst_b",    if_inst,                  32'h2222_2222);
      if_addr = 32'h0000_100C;
      tick();
      chk("t2_done_c",    {31'd0, if_done},         32'd1);
      chk("t2_inst_c",    if_inst,                  32'h4444_4444);
      chk("t2_rdvalid",   {31'd0, icache_rd_valid}, 32'd0);
      if_req = 1'b0;
      tick();
      chk("t2_pulse",     {31'd0, if_done},         32'd0);

      // Test 3: conflict on index 0
      if_req = 1'b1; if_addr = 32'h0000_1000;
      tick();
      chk("t3_hit",       {31'd0, if_done},         32'd1);
      if_addr = 32'h0000_1400;
      tick();
      if_req = 1'b0;
      chk("t3_miss_done", {31'd0, if_done},         32'd0);
      chk("t3_rdvalid",   {31'd0, icache_rd_valid}, 32'd1);
      chk("t3_rdaddr",    icache_rd_addr,           32'h0000_1400);
      tick(); tick(); tick();
      icache_ena = 1'b1; icache_rd_line = L2;
      tick();
      icache_ena = 1'b0;
      chk("t3_fill_done", {31'd0, if_done},         32'd1);
      chk("t3_fill_inst", if_inst,                  32'hAAAA_AAAA);
      if_req = 1'b1; if_addr = 32'h0000_1000;
      tick();
      if_req = 1'b0;
      chk("t3_remiss",    {31'd0, icache_rd_valid}, 32'd1);
      chk("t3_remiss_a",  icache_rd_addr,           32'h0000_1000);
      chk("t3_remiss_d",  {31'd0, if_done},         32'd0);
      tick();
      icache_ena = 1'b1; icache_rd_line = L1;
      tick();
      icache_ena = 1'b0;
      chk("t3_refill",    if_inst,                  32'h1111_1111);
      chk("t3_refill_d",  {31'd0, if_done},         32'd1);

      // Test 4: flush during miss, line still filled
      if_req = 1'b1; if_addr = 32'h0000_2000;
      tick();
      if_req = 1'b0;
      chk("t4_rdvalid",   {31'd0, icache_rd_valid}, 32'd1);
      tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t4_drain_v",   {31'd0, icache_rd_valid}, 32'd1);
      chk("t4_drain_r",   {31'd0, if_ready},        32'd0);
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("t4_wait_done",  {31'd0, if_done},  32'd0);
         chk("t4_wait_ready", {31'd0, if_ready}, 32'd0);
      end
      icache_ena = 1'b1; icache_rd_line = L3;
      tick();
      icache_ena = 1'b0;
      chk("t4_nodone",    {31'd0, if_done},         32'd0);
      chk("t4_rdvalid0",  {31'd0, icache_rd_valid}, 32'd0);
      chk("t4_ready1",    {31'd0, if_ready},        32'd1);
      if_req = 1'b1; if_addr = 32'h0000_2004;
      tick();
      if_req = 1'b0;
      chk("t4_hit_done",  {31'd0, if_done},         32'd1);
      chk("t4_hit_inst",  if_inst,                  32'h6666_6666);

      // Flush in IDLE drops a request that would otherwise miss
      if_req = 1'b1; if_addr = 32'h0000_1000; flush = 1'b1;
      tick();
      if_req = 1'b0; flush = 1'b0;
      chk("fi_done",      {31'd0, if_done},         32'd0);
      chk("fi_rdvalid",   {31'd0, icache_rd_valid}, 32'd0);
      chk("fi_ready",     {31'd0, if_ready},        32'd1);

      // Test 5: stall mid-miss, then flush and ena together
      if_req = 1'b1; if_addr = 32'h0000_3010;
      tick();
      if_req = 1'b0;
      chk("t5_rdvalid",   {31'd0, icache_rd_valid}, 32'd1);
      chk("t5_rdaddr",    icache_rd_addr,           32'h0000_3010);
      rdy = 1'b0; icache_ena = 1'b1; icache_rd_line = LX;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t5_stall_v",  {31'd0, icache_rd_valid}, 32'd1);
         chk("t5_stall_a",  icache_rd_addr,           32'h0000_3010);
         chk("t5_stall_r",  {31'd0, if_ready},        32'd0);
      end
      rdy = 1'b1; flush = 1'b1; icache_rd_line = L4;
      tick();
      icache_ena = 1'b0; flush = 1'b0;
      chk("t5_nodone",    {31'd0, if_done},         32'd0);
      chk("t5_rdvalid0",  {31'd0, icache_rd_valid}, 32'd0);
      chk("t5_ready1",    {31'd0, if_ready},        32'd1);
      chk("t5_inst_hold", if_inst,                  32'h6666_6666);
      if_req = 1'b1; if_addr = 32'h0000_3014;
      tick();
      if_req = 1'b0;
      chk("t5_hit_done",  {31'd0, if_done},         32'd1);
      chk("t5_hit_inst",  if_inst,                  32'hCAFE_0001);

      // Test 6: async reset mid-MISS
      if_req = 1'b1; if_addr = 32'h0000_4028;
      tick();
      if_req = 1'b0;
      chk("t6_rdvalid",   {31'd0, icache_rd_valid}, 32'd1);
      chk("t6_rdaddr",    icache_rd_addr,           32'h0000_4020);
      tick();
      #2 rst = 1'b0;
      #1;
      chk("t6_async_v",   {31'd0, icache_rd_valid}, 32'd0);
      chk("t6_async_a",   icache_rd_addr,           32'd0);
      chk("t6_async_r",   {31'd0, if_ready},        32'd1);
      chk("t6_async_i",   if_inst,                  32'd0);
      tick();
      rst = 1'b1;
      icache_ena = 1'b1; icache_rd_line = L5;
      tick();
      icache_ena = 1'b0;
      chk("t6_stray_d",   {31'd0, if_done},         32'd0);
      chk("t6_stray_v",   {31'd0, icache_rd_valid}, 32'd0);
      if_req = 1'b1; if_addr = 32'h0000_4028;
      tick();
      if_req = 1'b0;
      chk("t6_miss_v",    {31'd0, icache_rd_valid}, 32'd1);
      chk("t6_miss_d",    {31'd0, if_done},         32'd0);
      tick();
      icache_ena = 1'b1; icache_rd_line = L5;
      tick();
      icache_ena = 1'b0;
      chk("t6_fill_d",    {31'd0, if_done},         32'd1);
      chk("t6_fill_i",    if_inst,                  32'h0B0B_0B02);
      tick();
      chk("t6_pulse",     {31'd0, if_done},         32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
